register_file_dumper: RTL and testbench
=======================================

// Module: register_file_dumper
// PURPOSE
//   Debug-side reader for the CPU register file. On request, it walks all registers through one read
//   port and streams every word out as bytes over a valid/ready channel, which feeds the debug-unit
//   UART transmitter. It sits beside the pipeline and only borrows a read port while the CPU is halted.
// PARAMETERS
//   NB_ADDR    5             register address width
//   NB_DATA    32            register word width; must be an integer multiple of NB_BYTE
//   NB_BYTE    8             output byte width
//   RAM_DEPTH  2**NB_ADDR    number of registers dumped (addresses 0..RAM_DEPTH-1)
// PORTS
//   i_clock         in   1        clock; all state changes on the rising edge
//   i_reset         in   1        synchronous, active-high reset
//   i_start         in   1        dump request; sampled only in IDLE
//   o_rf_read_addr  out  NB_ADDR  register-file read address (combinational read port)
//   i_rf_data       in   NB_DATA  register-file read data for o_rf_read_addr, same cycle
//   o_tx_data       out  NB_BYTE  current output byte
//   o_tx_valid      out  1        o_tx_data is valid
//   i_tx_ready      in   1        sink accepts a byte when o_tx_valid and i_tx_ready are both high
//   o_busy          out  1        high in every state except IDLE
//   o_done          out  1        single-cycle pulse after the last byte is accepted
// BEHAVIOUR
//   Reset: i_reset high at an edge -> state IDLE; reg index, byte index and shift register cleared.
//     o_rf_read_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0. Reset wins over every other input.
//   BYTES_PER_WORD = NB_DATA/NB_BYTE (4 by default). Counters wrap only under the rules below.
//   FSM: IDLE -> FETCH -> SEND -> (FETCH | DONE) -> IDLE.
//   IDLE: o_busy=0, o_tx_valid=0. i_start=1 at an edge -> FETCH with reg index=0.
//   FETCH (1 cycle): o_rf_read_addr=reg index. At the closing edge, i_rf_data loads the shift register,
//     byte index=0, next state SEND.
//   SEND: o_tx_valid=1; o_tx_data=shift register[NB_BYTE-1:0], so bytes go out LSB first.
//     - valid & !ready: hold state; o_tx_data and o_tx_valid stay stable. o_tx_valid never drops before
//       the byte is accepted.
//     - valid & ready, more bytes left: shift right by NB_BYTE and increment the byte index.
//     - valid & ready on the last byte: if reg index==RAM_DEPTH-1 -> DONE; else reg index+1 -> FETCH.
//   DONE (1 cycle): o_done=1, o_tx_valid=0, o_busy=1; next state IDLE.
//   o_rf_read_addr holds the current reg index in FETCH/SEND and is 0 in IDLE/DONE.
//   Latency: i_start sampled at edge N -> first o_tx_valid in cycle N+2. With i_tx_ready tied high,
//     each register costs 1+BYTES_PER_WORD cycles, so o_done pulses 160 cycles after FETCH of reg 0
//     (default parameters).
//   i_start while o_busy=1 is ignored (no restart, no queueing). If i_start is still high in the
//     IDLE cycle after DONE, a new dump begins.
//   i_rf_data is sampled only at the closing edge of FETCH. Register writes during SEND do not
//     change the byte currently being sent.
//   i_reset mid-dump: the partially sent word is abandoned and no o_done pulse occurs. The next
//     i_start restarts from reg 0.
// TESTING
//   Model register file preloaded with reg[i]=32'hA000_0000+i.
//   1. Pulse i_start, i_tx_ready=1 -> 128 bytes: 00,00,00,A0, 01,00,00,A0, ... 1F,00,00,A0;
//      first valid 2 cycles after start; o_done pulses once, exactly 160 cycles after reg-0 FETCH.
//   2. Random i_tx_ready (~50%) -> same 128-byte sequence with no drops or duplicates; o_tx_data and
//      o_tx_valid are stable on every valid & !ready cycle.
//   3. Pulse i_start again during byte 10 -> ignored: exactly 128 bytes total, one o_done.
//   4. Assert i_reset during byte 50 -> next cycle all outputs are 0 and the state is IDLE; a new
//      i_start yields 00,00,00,A0 first.
//   5. Assert i_start and i_reset in the same cycle -> stays IDLE, o_busy=0, no bytes sent.
//   6. Hold i_start high throughout -> back-to-back dumps, each with 128 bytes and one o_done;
//      o_busy low for exactly 1 cycle between dumps.

Source files
------------

// File: rtl/register_file_dumper.sv
// ============================================================================
// Module   : register_file_dumper
// Brief    : Walks the register file through one read port and streams every
//            word out LSB-byte first over a valid/ready channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_dumper #(
   parameter int NB_ADDR   = 5,
   parameter int NB_DATA   = 32,
   parameter int NB_BYTE   = 8,
   parameter int RAM_DEPTH = 2**NB_ADDR
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   output logic [NB_ADDR-1:0] o_rf_read_addr,
   input  logic [NB_DATA-1:0] i_rf_data,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic               o_done
);

   localparam int c_bytes_per_word = NB_DATA / NB_BYTE;
   localparam int c_nb_bidx        = (c_bytes_per_word > 1) ? $clog2(c_bytes_per_word) : 1;
   localparam logic [NB_ADDR-1:0]   c_last_reg  = NB_ADDR'(RAM_DEPTH - 1);
   localparam logic [c_nb_bidx-1:0] c_last_byte = c_nb_bidx'(c_bytes_per_word - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SEND  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [NB_ADDR-1:0]   reg_idx_q, reg_idx_d;
   logic [c_nb_bidx-1:0] byte_idx_q, byte_idx_d;
   logic [NB_DATA-1:0]   shift_q, shift_d;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= S_IDLE;
         reg_idx_q  <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
      end else begin
         state_q    <= state_d;
         reg_idx_q  <= reg_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      reg_idx_d      = reg_idx_q;
      byte_idx_d     = byte_idx_q;
      shift_d        = shift_q;
      o_rf_read_addr = '0;
      o_tx_data      = '0;
      o_tx_valid     = 1'b0;
      o_busy         = 1'b1;
      o_done         = 1'b0;

      case (state_q)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_start) begin
               reg_idx_d = '0;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: begin
            o_rf_read_addr = reg_idx_q;
            shift_d        = i_rf_data;
            byte_idx_d     = '0;
            state_d        = S_SEND;
         end
         S_SEND: begin
            o_rf_read_addr = reg_idx_q;
            o_tx_valid     = 1'b1;
            o_tx_data      = shift_q[NB_BYTE-1:0];
            // Nothing moves until the sink takes the byte, so data stays stable while stalled.
            if (i_tx_ready) begin
               if (byte_idx_q != c_last_byte) begin
                  shift_d    = shift_q >> NB_BYTE;
                  byte_idx_d = byte_idx_q + c_nb_bidx'(1);
               end else if (reg_idx_q == c_last_reg) begin
                  state_d = S_DONE;
               end else begin
                  reg_idx_d = reg_idx_q + NB_ADDR'(1);
                  state_d   = S_FETCH;
               end
            end
         end
         S_DONE: begin
            o_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_register_file_dumper.sv
// ============================================================================
// Module   : tb_register_file_dumper
// Brief    : Directed self-checking bench for register_file_dumper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_dumper;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic [4:0]  o_rf_read_addr;
   logic [31:0] i_rf_data;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic        o_busy;
   logic        o_done;

   int checks = 0;
   int errors = 0;

   register_file_dumper dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_start        (i_start),
      .o_rf_read_addr (o_rf_read_addr),
      .i_rf_data      (i_rf_data),
      .o_tx_data      (o_tx_data),
      .o_tx_valid     (o_tx_valid),
      .i_tx_ready     (i_tx_ready),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   always #5 i_clock = ~i_clock;

   // Model register file: reg[i] = A000_0000 + i
   assign i_rf_data = 32'hA000_0000 + {27'd0, o_rf_read_addr};

   function automatic logic [7:0] exp_byte(input int k);
      logic [31:0] w;
      w = 32'hA000_0000 + 32'(k / 4);
      return w[8*(k % 4) +: 8];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one dump starting with the FETCH cycle of reg 0 as cycle 1.
   task automatic collect(input bit rnd, input int start_byte, input bit hold, input string tag);
      int cyc = 0, nbytes = 0, ndone = 0, first_valid = -1, done_cyc = -1;
      int seq_bad = 0, stall_bad = 0;
      bit stall = 1'b0;
      logic [7:0] last = '0;
      while (ndone == 0 && cyc < 2000) begin
         @(negedge i_clock);
         cyc++;
         if (!hold) i_start = (cyc > 1 && nbytes == start_byte);
         if (o_tx_valid && first_valid < 0) first_valid = cyc;
         if (stall && !(o_tx_valid === 1'b1 && o_tx_data === last)) stall_bad++;
         if (o_done) begin
            ndone++;
            done_cyc = cyc;
         end
         i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (o_tx_valid && i_tx_ready) begin
            if (o_tx_data !== exp_byte(nbytes)) seq_bad++;
            nbytes++;
         end
         stall = o_tx_valid && !i_tx_ready;
         last  = o_tx_data;
      end
      if (!hold) i_start = 1'b0;
      check({tag, "_seq"},    seq_bad,   0);
      check({tag, "_nbytes"}, nbytes,    128);
      check({tag, "_ndone"},  ndone,     1);
      check({tag, "_stall"},  stall_bad, 0);
      if (!rnd) begin
         check({tag, "_first_valid"}, first_valid, 2);
         check({tag, "_done_cyc"},    done_cyc,    161);
      end
   endtask

   initial begin
      int n, dn;
      i_reset    = 1'b1;
      i_start    = 1'b0;
      i_tx_ready = 1'b0;
      repeat (2) @(negedge i_clock);
      check("rst_addr",  o_rf_read_addr, 0);
      check("rst_data",  o_tx_data,      0);
      check("rst_valid", o_tx_valid,     0);
      check("rst_busy",  o_busy,         0);
      check("rst_done",  o_done,         0);
      i_reset = 1'b0;
      @(negedge i_clock);

      // 1: ready tied high
      i_start = 1'b1;
      collect(1'b0, -1, 1'b0, "t1");
      @(negedge i_clock);
      check("t1_idle_busy", o_busy, 0);

      // 2: random back-pressure
      i_start = 1'b1;
      collect(1'b1, -1, 1'b0, "t2");
      @(negedge i_clock);

      // 3: restart request during byte 10 must be ignored
      i_start = 1'b1;
      collect(1'b0, 10, 1'b0, "t3");
      repeat (3) @(negedge i_clock);
      check("t3_no_restart", o_busy, 0);

      // 4: reset during byte 50
      i_tx_ready = 1'b1;
      i_start    = 1'b1;
      @(negedge i_clock);
      i_start = 1'b0;
      n  = 0;
      dn = 0;
      for (int c = 0; c < 400 && n < 50; c++) begin
         @(negedge i_clock);
         if (o_done) dn++;
         if (o_tx_valid) n++;
      end
      @(negedge i_clock);
      check("t4_byte50", {o_tx_valid, o_tx_data}, {1'b1, exp_byte(50)});
      i_reset = 1'b1;
      @(negedge i_clock);
      check("t4_addr",  o_rf_read_addr, 0);
      check("t4_data",  o_tx_data,      0);
      check("t4_valid", o_tx_valid,     0);
      check("t4_busy",  o_busy,         0);
      check("t4_done",  o_done,         0);
      i_reset = 1'b0;
      repeat (3) begin
         @(negedge i_clock);
         if (o_done || o_busy) dn++;
      end
      check("t4_no_done_idle", dn, 0);
      i_start = 1'b1;
      collect(1'b0, -1, 1'b0, "t4r");
      @(negedge i_clock);

      // 5: start and reset together
      i_start = 1'b1;
      i_reset = 1'b1;
      @(negedge i_clock);
      check("t5_busy",  o_busy,     0);
      check("t5_valid", o_tx_valid, 0);
      i_start = 1'b0;
      i_reset = 1'b0;
      @(negedge i_clock);
      check("t5_idle_busy", o_busy, 0);

      // 6: start held high, back-to-back dumps
      i_start = 1'b1;
      collect(1'b0, -1, 1'b1, "t6a");
      @(negedge i_clock);
      check("t6_gap_busy", o_busy, 0);
      collect(1'b0, -1, 1'b1, "t6b");
      i_start = 1'b0;
      @(negedge i_clock);
      check("t6_end_busy", o_busy, 0);
      @(negedge i_clock);
      check("t6_stay_idle", o_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
